// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle controller: state encodings,
// instruction classes, opcode/func constants and ALU operation codes.
package mc_pkg;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CLS_RTYPE,
    CLS_IMM,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_BNE,
    CLS_J,
    CLS_ILLEGAL
  } op_class_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2a;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;
  localparam logic [2:0] ALU_LUI = 3'd5;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decode: classifies op/func and picks the ALU
// operation and immediate extension mode for the instruction.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output op_class_t  op_class,
  output logic [2:0] alu_op,
  output logic       need_sign_extend
);

  always_comb begin
    op_class         = CLS_ILLEGAL;
    alu_op           = ALU_ADD;
    need_sign_extend = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (func)
          FN_ADDU: begin op_class = CLS_RTYPE; alu_op = ALU_ADD; end
          FN_SUBU: begin op_class = CLS_RTYPE; alu_op = ALU_SUB; end
          FN_AND:  begin op_class = CLS_RTYPE; alu_op = ALU_AND; end
          FN_OR:   begin op_class = CLS_RTYPE; alu_op = ALU_OR;  end
          FN_SLT:  begin op_class = CLS_RTYPE; alu_op = ALU_SLT; end
          default: ;
        endcase
      end
      OP_ADDIU: begin op_class = CLS_IMM; alu_op = ALU_ADD; need_sign_extend = 1'b1; end
      OP_SLTI:  begin op_class = CLS_IMM; alu_op = ALU_SLT; need_sign_extend = 1'b1; end
      OP_ANDI:  begin op_class = CLS_IMM; alu_op = ALU_AND; end
      OP_ORI:   begin op_class = CLS_IMM; alu_op = ALU_OR;  end
      OP_LUI:   begin op_class = CLS_IMM; alu_op = ALU_LUI; end
      OP_LW:    begin op_class = CLS_LW;  alu_op = ALU_ADD; need_sign_extend = 1'b1; end
      OP_SW:    begin op_class = CLS_SW;  alu_op = ALU_ADD; need_sign_extend = 1'b1; end
      OP_BEQ:   begin op_class = CLS_BEQ; alu_op = ALU_SUB; need_sign_extend = 1'b1; end
      OP_BNE:   begin op_class = CLS_BNE; alu_op = ALU_SUB; need_sign_extend = 1'b1; end
      OP_J:     begin op_class = CLS_J;   alu_op = ALU_ADD; end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS-subset control FSM (IF/ID/EX/MEM/WB). Outputs are a decode
// of the current state and instruction, and are all forced low while in reset.
module mc_controller
  import mc_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic       need_sign_extend,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [2:0] alu_op,
  output logic [2:0] state,
  output logic       illegal
);

  state_t     state_q;
  state_t     next_state;
  op_class_t  op_class;
  logic [2:0] dec_alu_op;
  logic       dec_sign_extend;

  mc_decode u_decode (
    .op               (op),
    .func             (func),
    .op_class         (op_class),
    .alu_op           (dec_alu_op),
    .need_sign_extend (dec_sign_extend)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IF;
    else        state_q <= next_state;
  end

  always_comb begin
    next_state       = state_q;
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    iord             = 1'b0;
    ir_write         = 1'b0;
    pc_write         = 1'b0;
    reg_write        = 1'b0;
    reg_dst          = 1'b0;
    mem_to_reg       = 1'b0;
    alu_src_a        = 1'b0;
    need_sign_extend = dec_sign_extend;
    alu_src_b        = 2'd0;
    pc_source        = 2'd0;
    alu_op           = ALU_ADD;
    illegal          = 1'b0;
    case (state_q)
      ST_IF: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
        if (mem_ready) begin
          pc_write   = 1'b1;
          alu_src_b  = 2'd1;
          next_state = ST_ID;
        end
      end
      ST_ID: begin
        alu_src_b = 2'd3;
        if (op_class == CLS_ILLEGAL) begin
          illegal    = 1'b1;
          next_state = ILLEGAL_HALT ? ST_HALT : ST_IF;
        end else begin
          next_state = ST_EX;
        end
      end
      ST_EX: begin
        alu_op = dec_alu_op;
        case (op_class)
          CLS_BEQ: begin pc_write = zero;  pc_source = 2'd1; next_state = ST_IF; end
          CLS_BNE: begin pc_write = !zero; pc_source = 2'd1; next_state = ST_IF; end
          CLS_J:   begin pc_write = 1'b1;  pc_source = 2'd2; next_state = ST_IF; end
          CLS_RTYPE: begin alu_src_a = 1'b1; alu_src_b = 2'd0; next_state = ST_WB; end
          CLS_IMM:   begin alu_src_a = 1'b1; alu_src_b = 2'd2; next_state = ST_WB; end
          CLS_LW, CLS_SW: begin alu_src_a = 1'b1; alu_src_b = 2'd2; next_state = ST_MEM; end
          default: next_state = ST_IF;
        endcase
      end
      ST_MEM: begin
        // Access type comes from the instruction class, so read and write stay exclusive
        iord      = 1'b1;
        mem_read  = (op_class == CLS_LW);
        mem_write = (op_class == CLS_SW);
        if (mem_ready) next_state = (op_class == CLS_LW) ? ST_WB : ST_IF;
      end
      ST_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (op_class == CLS_RTYPE);
        mem_to_reg = (op_class == CLS_LW);
        next_state = ST_IF;
      end
      ST_HALT: begin
        need_sign_extend = 1'b0;
        next_state       = ST_HALT;
      end
      default: next_state = ST_IF;
    endcase
    if (!rst_n) begin
      mem_read         = 1'b0;
      mem_write        = 1'b0;
      iord             = 1'b0;
      ir_write         = 1'b0;
      pc_write         = 1'b0;
      reg_write        = 1'b0;
      reg_dst          = 1'b0;
      mem_to_reg       = 1'b0;
      alu_src_a        = 1'b0;
      need_sign_extend = 1'b0;
      alu_src_b        = 2'd0;
      pc_source        = 2'd0;
      alu_op           = ALU_ADD;
      illegal          = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: two instances (ILLEGAL_HALT=0/1) share
// stimulus; a phase-level reference model queues expected outputs per cycle.
module tb_mc_controller;

  typedef struct packed {
    logic [2:0] state;
    logic       illegal;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic       need_sign_extend;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
  } obs_t;

  typedef enum int {P_IF, P_ID, P_EX, P_MEM, P_WB, P_HALT, P_RST} phase_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = 6'd0;
  logic [5:0] func = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic       mem_read0, mem_write0, iord0, ir_write0, pc_write0, reg_write0;
  logic       reg_dst0, mem_to_reg0, alu_src_a0, nse0, illegal0;
  logic [1:0] alu_src_b0, pc_source0;
  logic [2:0] alu_op0, state0;
  logic       mem_read1, mem_write1, iord1, ir_write1, pc_write1, reg_write1;
  logic       reg_dst1, mem_to_reg1, alu_src_a1, nse1, illegal1;
  logic [1:0] alu_src_b1, pc_source1;
  logic [2:0] alu_op1, state1;

  obs_t obs0, obs1;
  obs_t q0[$];
  obs_t q1[$];
  bit   halted1 = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  logic [5:0] legalOps [11] = '{6'd0, 6'd9, 6'd10, 6'd12, 6'd13, 6'd15, 6'd35, 6'd43, 6'd4, 6'd5, 6'd2};
  logic [5:0] rFuncs [5] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2a};

  mc_controller #(.ILLEGAL_HALT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read0), .mem_write(mem_write0), .iord(iord0), .ir_write(ir_write0),
    .pc_write(pc_write0), .reg_write(reg_write0), .reg_dst(reg_dst0), .mem_to_reg(mem_to_reg0),
    .alu_src_a(alu_src_a0), .need_sign_extend(nse0), .alu_src_b(alu_src_b0),
    .pc_source(pc_source0), .alu_op(alu_op0), .state(state0), .illegal(illegal0)
  );

  mc_controller #(.ILLEGAL_HALT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read1), .mem_write(mem_write1), .iord(iord1), .ir_write(ir_write1),
    .pc_write(pc_write1), .reg_write(reg_write1), .reg_dst(reg_dst1), .mem_to_reg(mem_to_reg1),
    .alu_src_a(alu_src_a1), .need_sign_extend(nse1), .alu_src_b(alu_src_b1),
    .pc_source(pc_source1), .alu_op(alu_op1), .state(state1), .illegal(illegal1)
  );

  assign obs0 = {state0, illegal0, mem_read0, mem_write0, iord0, ir_write0, pc_write0,
                 reg_write0, reg_dst0, mem_to_reg0, alu_src_a0, nse0, alu_src_b0,
                 pc_source0, alu_op0};
  assign obs1 = {state1, illegal1, mem_read1, mem_write1, iord1, ir_write1, pc_write1,
                 reg_write1, reg_dst1, mem_to_reg1, alu_src_a1, nse1, alu_src_b1,
                 pc_source1, alu_op1};

  always #5 clk = ~clk;

  function automatic bit isLegal(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'd0) return (f == 6'h21 || f == 6'h23 || f == 6'h24 || f == 6'h25 || f == 6'h2a);
    return (o == 6'd9 || o == 6'd10 || o == 6'd12 || o == 6'd13 || o == 6'd15 ||
            o == 6'd35 || o == 6'd43 || o == 6'd4 || o == 6'd5 || o == 6'd2);
  endfunction

  function automatic logic nseRef(input logic [5:0] o);
    return (o == 6'd9 || o == 6'd10 || o == 6'd35 || o == 6'd43 || o == 6'd4 || o == 6'd5);
  endfunction

  function automatic logic [2:0] aluRef(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'd0) begin
      if (f == 6'h23) return 3'd1;
      if (f == 6'h24) return 3'd2;
      if (f == 6'h25) return 3'd3;
      if (f == 6'h2a) return 3'd4;
      return 3'd0;
    end
    if (o == 6'd10) return 3'd4;
    if (o == 6'd12) return 3'd2;
    if (o == 6'd13) return 3'd3;
    if (o == 6'd15) return 3'd5;
    if (o == 6'd4 || o == 6'd5) return 3'd1;
    return 3'd0;
  endfunction

  // Expected outputs for one cycle spent in a given instruction phase.
  function automatic obs_t refOut(input phase_t ph, input logic [5:0] o, input logic [5:0] f,
                                  input logic z, input logic mr);
    obs_t e;
    bit   isR, isLw, isSw, isBr, isJ;
    e    = '0;
    isR  = (o == 6'd0);
    isLw = (o == 6'd35);
    isSw = (o == 6'd43);
    isBr = (o == 6'd4 || o == 6'd5);
    isJ  = (o == 6'd2);
    if (ph == P_HALT) begin e.state = 3'd7; return e; end
    if (ph == P_RST) return e;
    e.need_sign_extend = nseRef(o);
    case (ph)
      P_IF: begin
        e.state = 3'd0; e.mem_read = 1'b1; e.ir_write = mr; e.pc_write = mr;
        e.alu_src_b = mr ? 2'd1 : 2'd0;
      end
      P_ID: begin
        e.state = 3'd1; e.alu_src_b = 2'd3; e.illegal = !isLegal(o, f);
      end
      P_EX: begin
        e.state = 3'd2; e.alu_op = aluRef(o, f);
        if (isBr) begin
          e.pc_write = (o == 6'd4) ? z : !z; e.pc_source = 2'd1;
        end else if (isJ) begin
          e.pc_write = 1'b1; e.pc_source = 2'd2;
        end else begin
          e.alu_src_a = 1'b1; e.alu_src_b = isR ? 2'd0 : 2'd2;
        end
      end
      P_MEM: begin
        e.state = 3'd3; e.iord = 1'b1; e.mem_read = isLw; e.mem_write = isSw;
      end
      P_WB: begin
        e.state = 3'd4; e.reg_write = 1'b1; e.reg_dst = isR; e.mem_to_reg = isLw;
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic checkOutput(input string name, input obs_t act, input obs_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h (state %0d) expected %h (state %0d) at %0t",
               name, act, act.state, exp, exp.state, $time);
    end
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f, input logic z,
                               input logic mr);
    @(posedge clk);
    #1;
    rst_n = 1'b1; op = o; func = f; zero = z; mem_ready = mr;
  endtask

  task automatic stepPhase(input phase_t ph, input logic [5:0] o, input logic [5:0] f,
                           input logic z, input logic mr);
    obs_t e;
    applyStimulus(o, f, z, mr);
    e = refOut(ph, o, f, z, mr);
    q0.push_back(e);
    q1.push_back(halted1 ? refOut(P_HALT, o, f, z, mr) : e);
    if (ph == P_ID && !isLegal(o, f)) halted1 = 1'b1;
  endtask

  task automatic doReset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      halted1 = 1'b0;
      q0.push_back(refOut(P_RST, 6'd0, 6'd0, 1'b0, 1'b0));
      q1.push_back(refOut(P_RST, 6'd0, 6'd0, 1'b0, 1'b0));
    end
  endtask

  // One instruction from fetch to retirement, with optional memory stalls.
  task automatic runInstr(input logic [5:0] o, input logic [5:0] f, input logic z,
                          input int ifWait, input int memWait);
    bit isLw, isSw, isBr, isJ;
    isLw = (o == 6'd35);
    isSw = (o == 6'd43);
    isBr = (o == 6'd4 || o == 6'd5);
    isJ  = (o == 6'd2);
    for (int i = 0; i < ifWait; i++) stepPhase(P_IF, o, f, z, 1'b0);
    stepPhase(P_IF, o, f, z, 1'b1);
    stepPhase(P_ID, o, f, z, 1'($urandom_range(0, 1)));
    if (!isLegal(o, f)) return;
    stepPhase(P_EX, o, f, z, 1'($urandom_range(0, 1)));
    if (isLw || isSw) begin
      for (int i = 0; i < memWait; i++) stepPhase(P_MEM, o, f, z, 1'b0);
      stepPhase(P_MEM, o, f, z, 1'b1);
    end
    if (isLw || !(isBr || isJ || isSw))
      stepPhase(P_WB, o, f, z, 1'($urandom_range(0, 1)));
  endtask

  task automatic resetDuringSwWait();
    stepPhase(P_IF, 6'd43, 6'd0, 1'b0, 1'b1);
    stepPhase(P_ID, 6'd43, 6'd0, 1'b0, 1'b1);
    stepPhase(P_EX, 6'd43, 6'd0, 1'b0, 1'b1);
    stepPhase(P_MEM, 6'd43, 6'd0, 1'b0, 1'b0);
    applyStimulus(6'd43, 6'd0, 1'b0, 1'b0);
    #2;
    checkValue("sw_wait_mem_write", int'(mem_write0), 1);
    rst_n = 1'b0;
    #1;
    checkValue("async_rst_mem_write0", int'(mem_write0), 0);
    checkValue("async_rst_mem_write1", int'(mem_write1), 0);
    checkValue("async_rst_state", int'(state0), 0);
    halted1 = 1'b0;
    q0.push_back(refOut(P_RST, 6'd0, 6'd0, 1'b0, 1'b0));
    q1.push_back(refOut(P_RST, 6'd0, 6'd0, 1'b0, 1'b0));
    doReset(1);
  endtask

  always @(negedge clk) begin
    if (q0.size() != 0) checkOutput("dut0_outputs", obs0, q0.pop_front());
    if (q1.size() != 0) checkOutput("dut1_outputs", obs1, q1.pop_front());
  end

  initial begin
    logic [5:0] o, f;
    doReset(2);
    runInstr(6'd9, 6'h3f, 1'b0, 0, 0);
    runInstr(6'd13, 6'h15, 1'b0, 0, 0);
    runInstr(6'd35, 6'h04, 1'b0, 0, 3);
    runInstr(6'd4, 6'h00, 1'b1, 0, 0);
    runInstr(6'd4, 6'h00, 1'b0, 0, 0);
    for (int n = 0; n < 60; n++) begin
      o = legalOps[$urandom_range(0, 10)];
      f = (o == 6'd0) ? rFuncs[$urandom_range(0, 4)] : 6'($urandom_range(0, 63));
      runInstr(o, f, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3));
    end
    resetDuringSwWait();
    runInstr(6'd0, 6'h2a, 1'b0, 0, 0);
    runInstr(6'd0, 6'h3f, 1'b0, 0, 0);
    runInstr(6'd63, 6'h00, 1'b0, 1, 0);
    runInstr(6'd2, 6'h00, 1'b0, 0, 0);
    runInstr(6'd43, 6'h00, 1'b0, 0, 1);
    for (int i = 0; i < 3; i++) stepPhase(P_IF, 6'd9, 6'h00, 1'b0, 1'b0);
    doReset(2);
    runInstr(6'd15, 6'h00, 1'b0, 0, 0);
    runInstr(6'd5, 6'h00, 1'b0, 0, 0);
    @(negedge clk);
    #1;
    checkValue("dut0_queue_drained", q0.size(), 0);
    checkValue("dut1_queue_drained", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
